// File: rtl/bsg_manycore_pod_reset_tag_tx.sv
// rtl/bsg_manycore_pod_reset_tag_tx.sv - serializes pod reset payloads onto the bsg_tag master data line
module bsg_manycore_pod_reset_tag_tx #(
  parameter int num_pods_x_p     = 1,
  parameter int num_pods_y_p     = 1,
  parameter int tag_els_p        = 16,
  parameter int tag_lg_width_p   = 4,
  parameter int payload_width_p  = 1,
  parameter int node_id_offset_p = 0,
  parameter int gap_cycles_p     = 4,
  localparam int x_width_lp = (num_pods_x_p > 1) ? $clog2(num_pods_x_p) : 1,
  localparam int y_width_lp = (num_pods_y_p > 1) ? $clog2(num_pods_y_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [x_width_lp-1:0]      pod_x_i,
  input  logic [y_width_lp-1:0]      pod_y_i,
  input  logic [payload_width_p-1:0] data_i,
  output logic                       ready_o,
  output logic                       tag_data_o,
  output logic                       busy_o,
  output logic                       init_done_o,
  output logic                       drop_o
);

  localparam int id_width_lp   = $clog2(tag_els_p);
  localparam int num_nodes_lp  = num_pods_x_p * num_pods_y_p;
  localparam int node_width_lp = (num_nodes_lp > 1) ? $clog2(num_nodes_lp) : 1;
  localparam int max_a_lp      = (id_width_lp > tag_lg_width_p) ? id_width_lp : tag_lg_width_p;
  localparam int max_b_lp      = (payload_width_p > gap_cycles_p) ? payload_width_p : gap_cycles_p;
  localparam int cnt_max_lp    = (max_a_lp > max_b_lp) ? max_a_lp : max_b_lp;
  localparam int cnt_width_lp  = $clog2(cnt_max_lp + 1);

  localparam logic [cnt_width_lp-1:0]   last_id_lp   = cnt_width_lp'(id_width_lp - 1);
  localparam logic [cnt_width_lp-1:0]   last_len_lp  = cnt_width_lp'(tag_lg_width_p - 1);
  localparam logic [cnt_width_lp-1:0]   last_pay_lp  = cnt_width_lp'(payload_width_p - 1);
  localparam logic [cnt_width_lp-1:0]   last_gap_lp  = cnt_width_lp'(gap_cycles_p - 1);
  localparam logic [node_width_lp-1:0]  last_node_lp = node_width_lp'(num_nodes_lp - 1);
  localparam logic [tag_lg_width_p-1:0] len_lp       = tag_lg_width_p'(payload_width_p);

  if (node_id_offset_p + num_nodes_lp > tag_els_p) begin : g_bad_node_range
    $error("pod node ids exceed tag_els_p");
  end
  if (gap_cycles_p < 1) begin : g_bad_gap
    $error("gap_cycles_p must be at least 1");
  end

  typedef enum logic [3:0] {
    INIT_RST, INIT_SET, IDLE, START, ID, DNR, LEN, DATA, GAP
  } state_e;

  state_e                       state_q, state_d;
  logic [cnt_width_lp-1:0]      cnt_q, cnt_d;
  logic [node_width_lp-1:0]     node_q, node_d;
  logic [id_width_lp-1:0]       id_q, id_d;
  logic [payload_width_p-1:0]   pay_q, pay_d;
  logic                         dnr_q, dnr_d;
  logic                         armed_q, armed_d;
  logic                         init_done_q, init_done_d;
  logic                         drop_q, drop_d;

  logic [id_width_lp-1:0] init_id, req_id;
  logic                   out_of_range;

  assign init_id = id_width_lp'(node_id_offset_p) + id_width_lp'(node_q);
  assign req_id  = id_width_lp'(node_id_offset_p)
                 + id_width_lp'(pod_y_i) * id_width_lp'(num_pods_x_p)
                 + id_width_lp'(pod_x_i);
  assign out_of_range = (32'(pod_x_i) >= 32'(num_pods_x_p))
                      | (32'(pod_y_i) >= 32'(num_pods_y_p));

  assign init_done_o = init_done_q;
  assign drop_o      = drop_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= INIT_RST;
      cnt_q       <= '0;
      node_q      <= '0;
      id_q        <= '0;
      pay_q       <= '0;
      dnr_q       <= 1'b0;
      armed_q     <= 1'b0;
      init_done_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      node_q      <= node_d;
      id_q        <= id_d;
      pay_q       <= pay_d;
      dnr_q       <= dnr_d;
      armed_q     <= armed_d;
      init_done_q <= init_done_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    node_d      = node_q;
    id_d        = id_q;
    pay_d       = pay_q;
    dnr_d       = dnr_q;
    armed_d     = 1'b1;
    init_done_d = init_done_q;
    drop_d      = 1'b0;
    tag_data_o  = 1'b0;
    busy_o      = 1'b0;
    ready_o     = 1'b0;

    unique case (state_q)
      // The first cycle out of reset is held quiet; the start bit follows.
      INIT_RST: begin
        if (armed_q) begin
          tag_data_o = 1'b1;
          busy_o     = 1'b1;
          id_d       = init_id;
          pay_d      = '0;
          dnr_d      = 1'b0;
          cnt_d      = '0;
          state_d    = ID;
        end
      end
      INIT_SET: begin
        tag_data_o = 1'b1;
        busy_o     = 1'b1;
        id_d       = init_id;
        pay_d      = payload_width_p'(1);
        dnr_d      = 1'b1;
        cnt_d      = '0;
        state_d    = ID;
      end
      IDLE: begin
        ready_o = init_done_q;
        if (v_i && init_done_q) begin
          if (out_of_range) begin
            drop_d = 1'b1;
          end else begin
            id_d    = req_id;
            pay_d   = data_i;
            dnr_d   = 1'b1;
            cnt_d   = '0;
            state_d = START;
          end
        end
      end
      START: begin
        tag_data_o = 1'b1;
        busy_o     = 1'b1;
        cnt_d      = '0;
        state_d    = ID;
      end
      ID: begin
        tag_data_o = |(id_q & (id_width_lp'(1) << cnt_q));
        busy_o     = 1'b1;
        if (cnt_q == last_id_lp) begin
          cnt_d   = '0;
          state_d = DNR;
        end else begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
      end
      DNR: begin
        tag_data_o = dnr_q;
        busy_o     = 1'b1;
        cnt_d      = '0;
        state_d    = LEN;
      end
      LEN: begin
        tag_data_o = |(len_lp & (tag_lg_width_p'(1) << cnt_q));
        busy_o     = 1'b1;
        if (cnt_q == last_len_lp) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
      end
      DATA: begin
        tag_data_o = |(pay_q & (payload_width_p'(1) << cnt_q));
        busy_o     = 1'b1;
        if (cnt_q == last_pay_lp) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
      end
      GAP: begin
        busy_o = 1'b1;
        if (cnt_q == last_gap_lp) begin
          cnt_d = '0;
          // dnr_q tells which init pass is running: 0 = client reset, 1 = reset-assert.
          if (init_done_q) begin
            state_d = IDLE;
          end else if (node_q == last_node_lp) begin
            node_d = '0;
            if (dnr_q) begin
              init_done_d = 1'b1;
              state_d     = IDLE;
            end else begin
              state_d = INIT_SET;
            end
          end else begin
            node_d  = node_q + node_width_lp'(1);
            state_d = dnr_q ? INIT_SET : INIT_RST;
          end
        end else begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
      end
      default: state_d = INIT_RST;
    endcase
  end

endmodule

// File: tb/tb_bsg_manycore_pod_reset_tag_tx.sv
// tb/tb_bsg_manycore_pod_reset_tag_tx.sv - self-checking bench for the pod reset tag transmitter
module tb_bsg_manycore_pod_reset_tag_tx;

  localparam int NX   = 2;
  localparam int NY   = 1;
  localparam int TELS = 16;
  localparam int LG   = 3;
  localparam int PW   = 1;
  localparam int OFF  = 0;
  localparam int GAP  = 4;
  localparam int ID_W = $clog2(TELS);
  localparam int PKT  = 2 + ID_W + LG + PW;
  localparam int XW   = 1;
  localparam int YW   = 1;
  localparam int INIT_LEN = 2 * NX * NY * (PKT + GAP);

  logic          clk_i, reset_i, v_i;
  logic [XW-1:0] pod_x_i;
  logic [YW-1:0] pod_y_i;
  logic [PW-1:0] data_i;
  logic          ready_o, tag_data_o, busy_o, init_done_o, drop_o;

  bsg_manycore_pod_reset_tag_tx #(
    .num_pods_x_p(NX), .num_pods_y_p(NY), .tag_els_p(TELS), .tag_lg_width_p(LG),
    .payload_width_p(PW), .node_id_offset_p(OFF), .gap_cycles_p(GAP)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .pod_x_i(pod_x_i), .pod_y_i(pod_y_i),
    .data_i(data_i), .ready_o(ready_o), .tag_data_o(tag_data_o), .busy_o(busy_o),
    .init_done_o(init_done_o), .drop_o(drop_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit   exp_q[$];
  logic drop_pend;
  logic init_done_m;
  logic cap[INIT_LEN];

  typedef struct {
    int         x;
    int         y;
    logic       d;
    logic       drop;
    logic [9:0] bits;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void push_pkt(input int node, input logic dnr, input int data);
    exp_q.push_back(1'b1);
    for (int i = 0; i < ID_W; i++) exp_q.push_back(1'(node >> i));
    exp_q.push_back(dnr);
    for (int i = 0; i < LG; i++) exp_q.push_back(1'(PW >> i));
    for (int i = 0; i < PW; i++) exp_q.push_back(1'(data >> i));
    for (int i = 0; i < GAP; i++) exp_q.push_back(1'b0);
  endfunction

  // One cycle: compare outputs to the model, then present new inputs and
  // tell the model whether the DUT will take them.
  task automatic tick(input logic v, input int x, input int y, input logic d, output logic acc);
    logic eb, et, er, ed;
    @(negedge clk_i);
    cyc++;
    eb = (exp_q.size() != 0);
    et = eb ? exp_q.pop_front() : 1'b0;
    if (!eb) init_done_m = 1'b1;
    er = init_done_m & ~eb;
    ed = drop_pend;
    drop_pend = 1'b0;
    chk("tag_data", tag_data_o, et);
    chk("busy", busy_o, eb);
    chk("ready", ready_o, er);
    chk("init_done", init_done_o, init_done_m);
    chk("drop", drop_o, ed);
    v_i     = v;
    pod_x_i = XW'(x);
    pod_y_i = YW'(y);
    data_i  = PW'(d);
    acc = v & er;
    if (acc) begin
      if (x >= NX || y >= NY) drop_pend = 1'b1;
      else push_pkt(OFF + y * NX + x, 1'b1, int'(d));
    end
  endtask

  task automatic do_reset(input int hold);
    reset_i = 1'b1;
    v_i     = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      cyc++;
      chk("rst_tag", tag_data_o, 1'b0);
      chk("rst_ready", ready_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_init_done", init_done_o, 1'b0);
      chk("rst_drop", drop_o, 1'b0);
    end
    reset_i = 1'b0;
    exp_q.delete();
    drop_pend   = 1'b0;
    init_done_m = 1'b0;
    for (int n = 0; n < NX * NY; n++) push_pkt(OFF + n, 1'b0, 0);
    for (int n = 0; n < NX * NY; n++) push_pkt(OFF + n, 1'b1, 1);
  endtask

  task automatic run_init();
    logic       acc;
    logic [9:0] got;
    for (int i = 0; i < INIT_LEN; i++) begin
      tick(1'b0, 0, 0, 1'b0, acc);
      cap[i] = tag_data_o;
      if (i == INIT_LEN - 1) chk("init_done_early", init_done_o, 1'b0);
    end
    tick(1'b0, 0, 0, 1'b0, acc);
    chk("init_done_rise", init_done_o, 1'b1);
    chk("ready_rise", ready_o, 1'b1);
    for (int i = 0; i < 10; i++) got[9-i] = cap[i];
    chk("init_pkt0_bits", got, 10'b1000001000);
    for (int i = 0; i < 10; i++) got[9-i] = cap[2 * (PKT + GAP) + i];
    chk("init_pkt2_bits", got, 10'b1000011001);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   x, n, t, acc_cyc[$];

    reset_i = 1'b1; v_i = 1'b0; pod_x_i = '0; pod_y_i = '0; data_i = '0;
    drop_pend = 1'b0; init_done_m = 1'b0;

    vecs[0] = '{1, 0, 1'b0, 1'b0, 10'b1100011000};
    vecs[1] = '{0, 0, 1'b1, 1'b0, 10'b1000011001};
    vecs[2] = '{1, 0, 1'b1, 1'b0, 10'b1100011001};
    vecs[3] = '{0, 1, 1'b0, 1'b1, 10'b0000000000};
    vecs[4] = '{0, 0, 1'b0, 1'b0, 10'b1000011000};
    vecs[5] = '{1, 1, 1'b1, 1'b1, 10'b0000000000};

    do_reset(2);
    run_init();

    foreach (vecs[k]) begin
      acc = 1'b0;
      for (int w = 0; w < 40 && !acc; w++) tick(1'b1, vecs[k].x, vecs[k].y, vecs[k].d, acc);
      if (!acc) chk("vec_accept_timeout", 32'd0, 32'd1);
      for (int i = 0; i < PKT; i++) begin
        tick(1'b0, 0, 0, 1'b0, acc);
        chk("vec_bits", tag_data_o, vecs[k].bits[PKT-1-i]);
        chk("vec_drop", drop_o, (i == 0) ? vecs[k].drop : 1'b0);
      end
      for (int i = 0; i < GAP; i++) tick(1'b0, 0, 0, 1'b0, acc);
    end

    // v_i held high, pod_x alternating after each acceptance.
    x = 0; n = 0;
    for (int w = 0; w < 100 && n < 3; w++) begin
      tick(1'b1, x, 0, 1'b0, acc);
      if (acc) begin
        acc_cyc.push_back(cyc);
        x = 1 - x;
        n++;
      end
    end
    if (n != 3) chk("hold_accept_count", n, 3);
    else begin
      chk("hold_spacing_01", acc_cyc[1] - acc_cyc[0], PKT + GAP + 1);
      chk("hold_spacing_12", acc_cyc[2] - acc_cyc[1], PKT + GAP + 1);
    end
    for (int i = 0; i < PKT + GAP + 1; i++) tick(1'b0, 0, 0, 1'b0, acc);

    for (int i = 0; i < 400; i++)
      tick(($urandom % 3) == 0, $urandom_range(0, 1), ($urandom % 4) == 0, 1'($urandom), acc);
    for (int i = 0; i < PKT + GAP + 1; i++) tick(1'b0, 0, 0, 1'b0, acc);

    // Reset while bit 5 of a request packet is on the line.
    acc = 1'b0;
    for (int w = 0; w < 40 && !acc; w++) tick(1'b1, 1, 0, 1'b1, acc);
    if (!acc) chk("midrst_accept_timeout", 32'd0, 32'd1);
    for (t = 0; t < 6; t++) tick(1'b0, 0, 0, 1'b0, acc);
    chk("midrst_bit5", tag_data_o, 1'b1);
    do_reset(1);
    run_init();
    for (int i = 0; i < 4; i++) tick(1'b0, 0, 0, 1'b0, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
